// File: rtl/knap_subset_enum_pkg.sv
// knap_pkg: shared types for the knapsack subset enumerator.
// Provides the total-width helper, the FSM state enum and the pipeline entry struct.
package knap_pkg;

    // Totals of up to n_items values of item_w bits never overflow this width.
    function automatic int sum_w(input int n_items, input int item_w);
        return item_w + $clog2(n_items) + 1;
    endfunction

    localparam int KNAP_N_ITEMS = 5;
    localparam int KNAP_ITEM_W  = 10;
    localparam int KNAP_SUM_W   = sum_w(KNAP_N_ITEMS, KNAP_ITEM_W);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } knap_state_e;

    typedef struct packed {
        logic [KNAP_N_ITEMS-1:0] mask;
        logic [KNAP_SUM_W-1:0]   value;
        logic [KNAP_SUM_W-1:0]   weight;
        logic                    feasible;
    } knap_entry_t;

endpackage

// File: rtl/knap_subset_enum_sum.sv
// knap_subset_sum: combinational sum of the packed items selected by a mask.
module knap_subset_sum import knap_pkg::*; #(
    parameter int N_ITEMS = KNAP_N_ITEMS,
    parameter int ITEM_W  = KNAP_ITEM_W,
    parameter int SUM_W   = sum_w(N_ITEMS, ITEM_W)
) (
    input  logic [N_ITEMS-1:0]        mask,
    input  logic [N_ITEMS*ITEM_W-1:0] items,
    output logic [SUM_W-1:0]          sum
);

    // Zero-extend each selected item and accumulate.
    always_comb begin
        sum = '0;
        for (int unsigned i = 0; i < N_ITEMS; i++) begin
            if (mask[i]) begin
                sum = sum + SUM_W'(items[i*ITEM_W +: ITEM_W]);
            end
        end
    end

endmodule

// File: rtl/knap_subset_enum.sv
// knap_subset_enum: enumerates all subset masks of N_ITEMS items, one per cycle,
// and streams the feasible ones (value >= min_value, weight <= max_weight)
// out on a valid/ready interface in ascending mask order.
// Optional build macro KNAP_BEST_TRACK_EN adds best-solution tracking outputs.
module knap_subset_enum import knap_pkg::*; #(
    parameter int   N_ITEMS = KNAP_N_ITEMS,
    parameter int   ITEM_W  = KNAP_ITEM_W,
    localparam int  SUM_W   = sum_w(N_ITEMS, ITEM_W)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    input  logic [N_ITEMS*ITEM_W-1:0]   item_weight,
    input  logic [N_ITEMS*ITEM_W-1:0]   item_value,
    input  logic [SUM_W-1:0]            min_value,
    input  logic [SUM_W-1:0]            max_weight,
    output logic                        busy,
    output logic                        done,
    output logic                        sol_valid,
    input  logic                        sol_ready,
    output logic [N_ITEMS-1:0]          sol_mask,
    output logic [SUM_W-1:0]            sol_value,
    output logic [SUM_W-1:0]            sol_weight,
    output logic [N_ITEMS:0]            sol_count
`ifdef KNAP_BEST_TRACK_EN
    ,
    output logic                        best_valid,
    output logic [N_ITEMS-1:0]          best_mask,
    output logic [SUM_W-1:0]            best_value
`endif
);

    localparam logic [N_ITEMS-1:0] MASK_ONE  = 1;
    localparam logic [N_ITEMS:0]   COUNT_ONE = 1;

    knap_state_e               state;
    logic [N_ITEMS-1:0]        cnt;

    // Configuration captured on the accepted start.
    logic [N_ITEMS*ITEM_W-1:0] cfg_weight;
    logic [N_ITEMS*ITEM_W-1:0] cfg_value;
    logic [SUM_W-1:0]          cfg_min;
    logic [SUM_W-1:0]          cfg_max;

    // Stage 1 holds one evaluated candidate.
    knap_entry_t               s1;
    logic                      s1_valid;

    logic [SUM_W-1:0]          cand_value;
    logic [SUM_W-1:0]          cand_weight;
    knap_entry_t               cand;

    logic                      start_ok;
    logic                      out_free;
    logic                      s1_leave;
    logic                      s1_load;

    knap_subset_sum #(
        .N_ITEMS (N_ITEMS),
        .ITEM_W  (ITEM_W),
        .SUM_W   (SUM_W)
    ) u_value_sum (
        .mask  (cnt),
        .items (cfg_value),
        .sum   (cand_value)
    );

    knap_subset_sum #(
        .N_ITEMS (N_ITEMS),
        .ITEM_W  (ITEM_W),
        .SUM_W   (SUM_W)
    ) u_weight_sum (
        .mask  (cnt),
        .items (cfg_weight),
        .sum   (cand_weight)
    );

    // Candidate evaluation and pipeline handshake decisions.
    // Stage 1 empties when its entry is infeasible (dropped) or the output can take it.
    always_comb begin
        cand          = '0;
        cand.mask     = cnt;
        cand.value    = cand_value;
        cand.weight   = cand_weight;
        cand.feasible = (cand_value >= cfg_min) && (cand_weight <= cfg_max);

        start_ok = (state == IDLE) && start;
        out_free = !sol_valid || sol_ready;
        s1_leave = s1_valid && (out_free || !s1.feasible);
        s1_load  = (state == RUN) && (!s1_valid || s1_leave);
    end

    // Control FSM: snapshot on start, walk the mask counter, then drain and pulse done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cfg_weight <= '0;
            cfg_value  <= '0;
            cfg_min    <= '0;
            cfg_max    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_weight <= item_weight;
                        cfg_value  <= item_value;
                        cfg_min    <= min_value;
                        cfg_max    <= max_weight;
                        cnt        <= '0;
                        busy       <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (s1_load) begin
                        cnt <= cnt + MASK_ONE;
                        if (cnt == '1) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (!s1_valid && !sol_valid) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1 and output register; a refill of the output register wins over its clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1         <= '0;
            s1_valid   <= 1'b0;
            sol_valid  <= 1'b0;
            sol_mask   <= '0;
            sol_value  <= '0;
            sol_weight <= '0;
            sol_count  <= '0;
        end else begin
            if (s1_load) begin
                s1       <= cand;
                s1_valid <= 1'b1;
            end else if (s1_leave) begin
                s1_valid <= 1'b0;
            end

            if (s1_leave && s1.feasible) begin
                sol_valid  <= 1'b1;
                sol_mask   <= s1.mask;
                sol_value  <= s1.value;
                sol_weight <= s1.weight;
            end else if (sol_valid && sol_ready) begin
                sol_valid <= 1'b0;
            end

            if (start_ok) begin
                sol_count <= '0;
            end else if (sol_valid && sol_ready) begin
                sol_count <= sol_count + COUNT_ONE;
            end
        end
    end

`ifdef KNAP_BEST_TRACK_EN
    // Best feasible value seen so far; strict compare keeps the lowest mask on ties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_valid <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
        end else if (start_ok) begin
            best_valid <= 1'b0;
            best_mask  <= '0;
            best_value <= '0;
        end else if (s1_leave && s1.feasible && (!best_valid || (s1.value > best_value))) begin
            best_valid <= 1'b1;
            best_mask  <= s1.mask;
            best_value <= s1.value;
        end
    end
`endif

endmodule

// File: tb/tb_knap_subset_enum.sv
// Self-checking bench for knap_subset_enum against a brute-force subset model.
module tb_knap_subset_enum;

    localparam int N  = 5;
    localparam int IW = 10;
    localparam int SW = IW + $clog2(N) + 1;
    localparam int NM = 1 << N;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sol_ready = 1'b0;
    logic [N*IW-1:0]   item_weight = '0;
    logic [N*IW-1:0]   item_value = '0;
    logic [SW-1:0]     min_value = '0;
    logic [SW-1:0]     max_weight = '0;
    logic              busy;
    logic              done;
    logic              sol_valid;
    logic [N-1:0]      sol_mask;
    logic [SW-1:0]     sol_value;
    logic [SW-1:0]     sol_weight;
    logic [N:0]        sol_count;
`ifdef KNAP_BEST_TRACK_EN
    logic              best_valid;
    logic [N-1:0]      best_mask;
    logic [SW-1:0]     best_value;
`endif

    int checks = 0;
    int errors = 0;

    int unsigned exp_mask[$];
    int unsigned exp_val[$];
    int unsigned exp_wt[$];
    bit          exp_best_ok;
    int unsigned exp_best_mask;
    int unsigned exp_best_val;

    always #5 clk = ~clk;

    knap_subset_enum #(
        .N_ITEMS (N),
        .ITEM_W  (IW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .item_weight (item_weight),
        .item_value  (item_value),
        .min_value   (min_value),
        .max_weight  (max_weight),
        .busy        (busy),
        .done        (done),
        .sol_valid   (sol_valid),
        .sol_ready   (sol_ready),
        .sol_mask    (sol_mask),
        .sol_value   (sol_value),
        .sol_weight  (sol_weight),
        .sol_count   (sol_count)
`ifdef KNAP_BEST_TRACK_EN
        ,
        .best_valid  (best_valid),
        .best_mask   (best_mask),
        .best_value  (best_value)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned item(input logic [N*IW-1:0] vec, input int i);
        return int'(vec[i*IW +: IW]);
    endfunction

    // Reference: try every subset, keep the feasible ones in ascending mask order.
    task automatic build_model(input logic [N*IW-1:0] w, input logic [N*IW-1:0] v,
                               input logic [SW-1:0] mn, input logic [SW-1:0] mx);
        exp_mask.delete();
        exp_val.delete();
        exp_wt.delete();
        exp_best_ok   = 0;
        exp_best_mask = 0;
        exp_best_val  = 0;
        for (int m = 0; m < NM; m++) begin
            int unsigned tv = 0;
            int unsigned tw = 0;
            for (int i = 0; i < N; i++) begin
                if (((m >> i) & 1) == 1) begin
                    tv += item(v, i);
                    tw += item(w, i);
                end
            end
            if (tv >= int'(mn) && tw <= int'(mx)) begin
                exp_mask.push_back(m);
                exp_val.push_back(tv);
                exp_wt.push_back(tw);
                if (!exp_best_ok || tv > exp_best_val) begin
                    exp_best_ok   = 1;
                    exp_best_mask = m;
                    exp_best_val  = tv;
                end
            end
        end
    endtask

    function automatic logic [N*IW-1:0] pack(input int unsigned a0, input int unsigned a1,
                                             input int unsigned a2, input int unsigned a3,
                                             input int unsigned a4);
        logic [N*IW-1:0] r;
        r = {IW'(a4), IW'(a3), IW'(a2), IW'(a1), IW'(a0)};
        return r;
    endfunction

    // mode 0: ready always 1 (also checks done timing); 1: random ready; 2: ready 0 for 10 cycles.
    task automatic run_search(input string name, input logic [N*IW-1:0] w, input logic [N*IW-1:0] v,
                              input logic [SW-1:0] mn, input logic [SW-1:0] mx, input int mode);
        int          c;
        int          idx;
        int          last_m;
        int          exp_done_c;
        bit          got_done;
        bit          prev_stall;
        logic [N-1:0]  pm;
        logic [SW-1:0] pv;
        logic [SW-1:0] pw;

        build_model(w, v, mn, mx);
        @(posedge clk); #1;
        item_weight = w;
        item_value  = v;
        min_value   = mn;
        max_weight  = mx;
        start       = 1'b1;
        sol_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        check({name, ":busy_after_start"}, busy, 1);
        check({name, ":count_cleared"}, sol_count, 0);
        // Scramble the inputs; the running search must use the snapshot.
        item_weight = {$urandom, $urandom};
        item_value  = {$urandom, $urandom};
        min_value   = SW'($urandom);
        max_weight  = SW'($urandom);

        idx = 0;
        last_m = -1;
        got_done = 0;
        prev_stall = 0;
        pm = '0;
        pv = '0;
        pw = '0;
        while (!got_done && c < 400) begin
            @(posedge clk); #1;
            c++;
            if (prev_stall) begin
                check({name, ":stall_valid"}, sol_valid, 1);
                check({name, ":stall_mask"}, sol_mask, pm);
                check({name, ":stall_value"}, sol_value, pv);
                check({name, ":stall_weight"}, sol_weight, pw);
            end
            if (done) begin
                got_done = 1;
                check({name, ":done_without_valid"}, sol_valid, 0);
                check({name, ":busy_clear_at_done"}, busy, 0);
                check({name, ":sol_count"}, sol_count, exp_mask.size());
                check({name, ":transfers"}, idx, exp_mask.size());
                if (mode == 0) begin
                    exp_done_c = (last_m + 4 > 34) ? last_m + 4 : 34;
                    check({name, ":done_cycle"}, c, exp_done_c);
                end
`ifdef KNAP_BEST_TRACK_EN
                check({name, ":best_valid"}, best_valid, exp_best_ok);
                if (exp_best_ok) begin
                    check({name, ":best_mask"}, best_mask, exp_best_mask);
                    check({name, ":best_value"}, best_value, exp_best_val);
                end
`endif
            end else begin
                check({name, ":busy"}, busy, 1);
                case (mode)
                    1: sol_ready = ($urandom_range(0, 3) != 0);
                    2: sol_ready = !(c >= 12 && c < 22);
                    default: sol_ready = 1'b1;
                endcase
                start = (c == 5);
                if (sol_valid && sol_ready) begin
                    if (idx < exp_mask.size()) begin
                        check({name, ":mask"}, sol_mask, exp_mask[idx]);
                        check({name, ":value"}, sol_value, exp_val[idx]);
                        check({name, ":weight"}, sol_weight, exp_wt[idx]);
                        last_m = int'(exp_mask[idx]);
                    end else begin
                        check({name, ":extra_transfer"}, idx, exp_mask.size() - 1);
                    end
                    idx++;
                end
                prev_stall = sol_valid && !sol_ready;
                pm = sol_mask;
                pv = sol_value;
                pw = sol_weight;
            end
        end
        start = 1'b0;
        check({name, ":done_seen"}, got_done, 1);
        if (got_done) begin
            @(posedge clk); #1;
            check({name, ":done_pulse"}, done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":busy"}, busy, 0);
        check({tag, ":done"}, done, 0);
        check({tag, ":sol_valid"}, sol_valid, 0);
        check({tag, ":sol_mask"}, sol_mask, 0);
        check({tag, ":sol_value"}, sol_value, 0);
        check({tag, ":sol_weight"}, sol_weight, 0);
        check({tag, ":sol_count"}, sol_count, 0);
`ifdef KNAP_BEST_TRACK_EN
        check({tag, ":best_valid"}, best_valid, 0);
`endif
    endtask

    logic [N*IW-1:0] bw;
    logic [N*IW-1:0] bv;
    logic [N*IW-1:0] rw;
    logic [N*IW-1:0] rv;
    logic [SW-1:0]   rmn;
    logic [SW-1:0]   rmx;
    int unsigned     tot_w;
    int unsigned     tot_v;
    bit              saw_done;

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_reset");

        bw = pack(12, 1, 2, 1, 4);
        bv = pack(4, 2, 2, 1, 10);
        run_search("baseline", bw, bv, SW'(15), SW'(16), 0);
        check("baseline:only_mask", exp_mask.size(), 1);
        run_search("all_feasible", bw, bv, '0, '1, 0);
        run_search("backpressure", bw, bv, '0, '1, 2);
        run_search("infeasible", bw, bv, SW'(100), '1, 0);

        // Abort a search asynchronously while the counter is around mask 9.
        @(posedge clk); #1;
        item_weight = bw;
        item_value  = bv;
        min_value   = '0;
        max_weight  = '1;
        start       = 1'b1;
        sol_ready   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midrun:busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        saw_done = 0;
        repeat (2) begin
            @(posedge clk); #1;
            saw_done = saw_done | done;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            saw_done = saw_done | done;
        end
        check("midrun:no_done", saw_done, 0);
        check("midrun:idle_busy", busy, 0);
        run_search("after_abort", bw, bv, '0, '1, 0);

        for (int k = 0; k < 6; k++) begin
            rw = '0;
            rv = '0;
            tot_w = 0;
            tot_v = 0;
            for (int i = 0; i < N; i++) begin
                int unsigned a;
                int unsigned b;
                a = $urandom_range(0, 1023);
                b = $urandom_range(0, 1023);
                rw[i*IW +: IW] = IW'(a);
                rv[i*IW +: IW] = IW'(b);
                tot_w += a;
                tot_v += b;
            end
            rmx = SW'($urandom_range(0, tot_w));
            rmn = (k == 0) ? '0 : SW'($urandom_range(0, tot_v / 2));
            run_search($sformatf("random%0d", k), rw, rv, rmn, rmx, (k % 2 == 0) ? 1 : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/knap_subset_enum.md
Name: knap_subset_enum

Overview:
- Sequential producer side of the knapsack feasibility check.
- On `start`, it enumerates every subset mask of `N_ITEMS` items, one candidate per cycle.
- For each candidate it accumulates total value and total weight, and keeps the candidate only if value ≥ `min_value` and weight ≤ `max_weight`.
- Feasible masks are streamed out on a valid/ready interface. Upstream is a control sequencer; downstream is a solution collector or host FIFO.

Parameters:
- N_ITEMS, 5, number of items; mask width; 2^N_ITEMS candidates.
- ITEM_W, 10, width of each per-item weight/value.
- SUM_W (localparam), ITEM_W+$clog2(N_ITEMS)+1, width of totals and thresholds; sums never overflow.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  single-cycle request to begin a search; ignored unless IDLE.
- item_weight  in  N_ITEMS*ITEM_W  packed weights, item i at [i*ITEM_W +: ITEM_W].
- item_value  in  N_ITEMS*ITEM_W  packed values, same packing.
- min_value  in  SUM_W  inclusive lower bound on total value.
- max_weight  in  SUM_W  inclusive upper bound on total weight.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the search is complete.
- sol_valid  out  1  feasible solution present on sol_*.
- sol_ready  in  1  downstream accepts; transfer when sol_valid & sol_ready.
- sol_mask  out  N_ITEMS  selected items; bit i = item i.
- sol_value  out  SUM_W  total value of sol_mask.
- sol_weight  out  SUM_W  total weight of sol_mask.
- sol_count  out  N_ITEMS+1  number of solutions transferred in the current/last search.

Behaviour:
- Reset values: busy=0, done=0, sol_valid=0, sol_mask/sol_value/sol_weight=0, sol_count=0, state IDLE, all pipeline valid bits 0.
- Reset mid-search aborts immediately; no done pulse is emitted.
- Configuration snapshot: item_weight, item_value, min_value and max_weight are registered on the accepted start. Later input changes do not affect the running search.
- FSM states:
  - IDLE: on start, snapshot config, mask counter=0, sol_count=0, go to RUN.
  - RUN: issue the counter mask into stage 1 whenever stage 1 can advance; increment the counter. After issuing all-ones, go to DRAIN.
  - DRAIN: wait until stage 1 and the output register are both empty, then pulse done for one cycle and go to IDLE.
- Pipeline:
  - Stage 1 registers mask, zero-extended totals (sum over set bits) and a feasible flag.
  - The output register holds only feasible entries; infeasible entries are dropped at the stage 1→output move.
- Advance rule: stage 1 may load when it is empty, or when its content is leaving (output register empty, or sol_ready=1, or the entry is infeasible).
- Backpressure: sol_valid=0 while sol_ready=0 never blocks. While sol_valid=1 and sol_ready=0, sol_* stays stable and enumeration stalls once stage 1 is full and feasible.
- Latency: the mask issued in cycle t is visible on sol_* at t+2 at the earliest.
- Ordering: solutions appear in strictly ascending mask order. Mask 0 is a candidate and is feasible only when min_value=0.
- sol_count increments on each transfer.
- start while busy is ignored.
- done may coincide with the cycle in which the last transfer completes plus one; it is never asserted while sol_valid=1.

Optional Feature:
- Macro: KNAP_BEST_TRACK_EN.
- When defined, adds outputs best_valid (1), best_mask (N_ITEMS) and best_value (SUM_W).
  - These update on each feasible entry entering the output register when its value > best_value, so ties keep the lowest mask.
  - They are cleared at start and held after done.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Package knap_pkg: SUM_W computation function, FSM state enum (IDLE, RUN, DRAIN), and a packed struct {mask, value, weight, feasible} for pipeline entries.
- One sub-module, knap_subset_sum: purely combinational masked sum of one packed ITEM_W vector to SUM_W. Instantiated twice, for value and weight.

Test Plan:
- Baseline: weights {12,1,2,1,4}, values {4,2,2,1,10} (items 0..4), min_value=15, max_weight=16, sol_ready=1, pulse start → exactly one transfer: mask=5'h1E, value=15, weight=8. Then done pulse, sol_count=1; with KNAP_BEST_TRACK_EN, best_mask=5'h1E.
- min_value=0, max_weight=max, sol_ready=1 → 32 transfers with masks 0..31 in order, on consecutive cycles after 2-cycle fill; done one cycle after the last transfer, sol_count=32.
- Same as previous, with sol_ready held 0 for 10 cycles mid-stream → sol_mask stable, no skipped or duplicated mask, sol_count=32.
- min_value=100 (infeasible) → no sol_valid; done after 2^5 issue cycles plus pipeline drain; sol_count=0.
- start re-pulsed during RUN, and input changes after start → no effect; results match the snapshot.
- rst_n low during RUN at mask 9 → all outputs reset asynchronously, no done; a new start then produces full correct results.
